// File: rtl/collision_pkg.sv
// Shared types for the collision scheduler: FSM state encoding, coordinate
// width and the hitbox record used for both the player and obstacle slots.
package collision_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [COORD_W-1:0] w;
    logic [COORD_W-1:0] h;
  } hitbox_t;

  // Far edge of a box along one axis. Callers keep pos+len within range,
  // so the sum is deliberately kept at coordinate width with no wrap check.
  function automatic logic [COORD_W-1:0] far_edge(input logic [COORD_W-1:0] pos,
                                                  input logic [COORD_W-1:0] len);
    return pos + len;
  endfunction

endpackage

// File: rtl/collision_scheduler_cmp.sv
// Axis-aligned hitbox overlap comparator. Purely combinational; the scheduler
// time-shares one instance across all obstacle slots. Boxes that only touch
// along an edge are not considered overlapping (strict inequalities).
module collision_scheduler_cmp
  import collision_pkg::*;
(
  input  hitbox_t a,
  input  hitbox_t b,
  output logic    overlap
);

  logic [COORD_W-1:0] a_right;
  logic [COORD_W-1:0] a_bottom;
  logic [COORD_W-1:0] b_right;
  logic [COORD_W-1:0] b_bottom;

  // Separating-axis test on both axes with strict comparisons
  always_comb begin
    a_right  = far_edge(a.x, a.w);
    a_bottom = far_edge(a.y, a.h);
    b_right  = far_edge(b.x, b.w);
    b_bottom = far_edge(b.y, b.h);
    overlap  = (a.x < b_right) && (b.x < a_right) &&
               (a.y < b_bottom) && (b.y < a_bottom);
  end

endmodule

// File: rtl/collision_scheduler.sv
// Collision scheduler: on Start, walks every obstacle slot through an external
// table with one-cycle read latency and compares each returned hitbox against
// the latched player hitbox. Reports whether any valid slot overlapped and the
// lowest such slot index. Results update together with the Done pulse and are
// held otherwise.
// Optional feature: define COLLISION_HIT_MASK_EN to add the HitMask port,
// a per-slot overlap bit vector of the last completed scan.
module collision_scheduler
  import collision_pkg::*;
#(
  parameter int NUM_OBJ = 16,
  parameter int IDX_W   = $clog2(NUM_OBJ)
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [COORD_W-1:0] PlayerX,
  input  logic [COORD_W-1:0] PlayerY,
  input  logic [COORD_W-1:0] PlayerW,
  input  logic [COORD_W-1:0] PlayerH,
  output logic [IDX_W-1:0]   ObjAddr,
  input  logic [COORD_W-1:0] ObjX,
  input  logic [COORD_W-1:0] ObjY,
  input  logic [COORD_W-1:0] ObjW,
  input  logic [COORD_W-1:0] ObjH,
  input  logic               ObjValid,
  output logic               Busy,
  output logic               Done,
  output logic               Hit,
  output logic [IDX_W-1:0]   HitIdx
`ifdef COLLISION_HIT_MASK_EN
  ,
  output logic [NUM_OBJ-1:0] HitMask
`endif
);

  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(NUM_OBJ - 1);

  state_t             state_reg;
  state_t             state_next;
  logic [IDX_W-1:0]   counter_reg;
  hitbox_t            player_reg;
  hitbox_t            obj_box;

  // Compare pipeline: address issued last cycle and whether it is a real slot
  logic               pend_valid_reg;
  logic [IDX_W-1:0]   pend_idx_reg;

  logic               overlap;
  logic               slot_hit;
  logic               start_accept;

  // Running accumulators for the scan in progress
  logic               acc_hit_reg;
  logic               acc_hit_next;
  logic [IDX_W-1:0]   acc_idx_reg;
  logic [IDX_W-1:0]   acc_idx_next;

  // Published result of the last completed scan
  logic               hit_reg;
  logic [IDX_W-1:0]   hit_idx_reg;

  assign start_accept = (state_reg == ST_IDLE) && Start;
  assign obj_box      = '{x: ObjX, y: ObjY, w: ObjW, h: ObjH};

  collision_scheduler_cmp u_cmp (
    .a       (player_reg),
    .b       (obj_box),
    .overlap (overlap)
  );

  assign slot_hit = pend_valid_reg && ObjValid && overlap;

  // State register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic; Start outside IDLE is simply not looked at
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (Start) state_next = ST_SCAN;
      ST_SCAN:  if (counter_reg == LAST_SLOT) state_next = ST_DRAIN;
      ST_DRAIN: state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Slot counter: runs only while addresses are being issued
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      counter_reg <= '0;
    end else if (start_accept) begin
      counter_reg <= '0;
    end else if (state_reg == ST_SCAN) begin
      counter_reg <= (counter_reg == LAST_SLOT) ? '0 : counter_reg + 1'b1;
    end
  end

  // Track which slot's data arrives next cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      pend_valid_reg <= 1'b0;
      pend_idx_reg   <= '0;
    end else begin
      pend_valid_reg <= (state_reg == ST_SCAN);
      pend_idx_reg   <= counter_reg;
    end
  end

  // Player hitbox is captured only when a request is accepted
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      player_reg <= '0;
    end else if (start_accept) begin
      player_reg <= '{x: PlayerX, y: PlayerY, w: PlayerW, h: PlayerH};
    end
  end

  // First hit wins: the index is only taken when no earlier slot has hit
  always_comb begin
    acc_hit_next = acc_hit_reg | slot_hit;
    acc_idx_next = acc_idx_reg;
    if (slot_hit && !acc_hit_reg) begin
      acc_idx_next = pend_idx_reg;
    end
  end

  // Accumulators cleared per request, updated for every returned slot
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_hit_reg <= 1'b0;
      acc_idx_reg <= '0;
    end else if (start_accept) begin
      acc_hit_reg <= 1'b0;
      acc_idx_reg <= '0;
    end else if (pend_valid_reg) begin
      acc_hit_reg <= acc_hit_next;
      acc_idx_reg <= acc_idx_next;
    end
  end

  // Publish results on the edge entering DONE, folding in the final slot
  // compared during DRAIN, so they are valid alongside the Done pulse
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_reg     <= 1'b0;
      hit_idx_reg <= '0;
    end else if (state_reg == ST_DRAIN) begin
      hit_reg     <= acc_hit_next;
      hit_idx_reg <= acc_idx_next;
    end
  end

`ifdef COLLISION_HIT_MASK_EN
  logic [NUM_OBJ-1:0] acc_mask_reg;
  logic [NUM_OBJ-1:0] acc_mask_next;
  logic [NUM_OBJ-1:0] hit_mask_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_OBJ; gi++) begin : g_mask
      assign acc_mask_next[gi] = acc_mask_reg[gi] |
                                 (slot_hit && (pend_idx_reg == IDX_W'(gi)));
    end
  endgenerate

  // Per-slot hit accumulator
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      acc_mask_reg <= '0;
    end else if (start_accept) begin
      acc_mask_reg <= '0;
    end else if (pend_valid_reg) begin
      acc_mask_reg <= acc_mask_next;
    end
  end

  // Published mask, updated together with Hit/HitIdx
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      hit_mask_reg <= '0;
    end else if (state_reg == ST_DRAIN) begin
      hit_mask_reg <= acc_mask_next;
    end
  end

  assign HitMask = hit_mask_reg;
`endif

  assign ObjAddr = (state_reg == ST_SCAN) ? counter_reg : '0;
  assign Busy    = (state_reg != ST_IDLE);
  assign Done    = (state_reg == ST_DONE);
  assign Hit     = hit_reg;
  assign HitIdx  = hit_idx_reg;

endmodule

// File: doc/collision_scheduler.md
COLLISION_SCHEDULER -- requirements
Module: collision_scheduler

Interface
REQ-001 Parameter NUM_OBJ, default 16: number of obstacle hitbox slots scanned per request (2..256).
REQ-002 Parameter IDX_W, default $clog2(NUM_OBJ): width of slot index.
REQ-003 Clk  in  1  single clock; all state on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Start  in  1  one-cycle request to scan all slots against the player hitbox.
REQ-006 PlayerX, PlayerY, PlayerW, PlayerH  in  10 each  player hitbox, sampled on accepted Start.
REQ-007 ObjAddr  out  IDX_W  slot address to obstacle table.
REQ-008 ObjX, ObjY, ObjW, ObjH  in  10 each  slot hitbox, valid exactly one cycle after ObjAddr.
REQ-009 ObjValid  in  1  slot occupied, same timing as ObjX.
REQ-010 Busy  out  1  high from cycle after accepted Start through the Done cycle.
REQ-011 Done  out  1  one-cycle pulse, scan complete.
REQ-012 Hit  out  1  at least one valid slot overlapped in last completed scan.
REQ-013 HitIdx  out  IDX_W  lowest overlapping slot index of last completed scan; 0 if none.
REQ-014 HitMask  out  NUM_OBJ  per-slot overlap bits (only with COLLISION_HIT_MASK_EN).

Function
REQ-015 States: IDLE, SCAN, DRAIN, DONE.
REQ-016 IDLE: Start=1 latches player hitbox, clears internal accumulators, counter=0 -> SCAN.
REQ-017 Start while Busy=1 is ignored; no queuing.
REQ-018 SCAN: ObjAddr=counter; counter increments every cycle; after issuing NUM_OBJ-1 -> DRAIN.
REQ-019 Pipelined compare: slot data returned in cycle k+1 is compared against the latched player hitbox for the address issued in cycle k.
REQ-020 Overlap: strict inequalities on all four edges; edge-touching boxes do not collide.
REQ-021 Slot counts as hit only if ObjValid=1 and overlap true.
REQ-022 First hit (lowest index) captured into internal index; later hits do not overwrite it.
REQ-023 DRAIN: compares final slot -> DONE.
REQ-024 DONE: Done=1 for one cycle; Hit/HitIdx/HitMask outputs load from accumulators on this edge -> IDLE.
REQ-025 Latency: Start sampled in cycle 0 -> Done high in cycle NUM_OBJ+2.
REQ-026 Outputs Hit/HitIdx/HitMask hold previous result throughout a scan; change only at Done.
REQ-027 ObjAddr holds 0 outside SCAN.
REQ-028 Coordinate sums are 10-bit; caller guarantees X+W and Y+H ≤ 1023; no wrap handling in block.
REQ-029 Start in DONE cycle ignored; Start in the following IDLE cycle accepted (back-to-back period NUM_OBJ+3).

Reset
REQ-030 Reset asserted at any time -> IDLE immediately; Busy=0, Done=0, Hit=0, HitIdx=0, HitMask=0, ObjAddr=0, counter=0.
REQ-031 Scan interrupted by Reset produces no Done and no result update.

Configuration
REQ-032 Macro COLLISION_HIT_MASK_EN defined: HitMask port exists, bit i set for every hitting slot i.
REQ-033 Macro undefined: HitMask port and its register absent; Hit/HitIdx behaviour identical.

Structure
REQ-034 Shared package collision_pkg: state enum type, COORD_W=10 constant, hitbox struct (x, y, w, h).
REQ-035 One sub-module: existing collision comparator, single instance, time-shared across slots.

Verification
REQ-036 Player (100,100,16,16), slot 3 = (110,110,8,8) valid, others invalid -> Done at cycle 18, Hit=1, HitIdx=3, HitMask=0x0008.
REQ-037 Slots 5 and 9 overlapping, slot 2 overlapping but ObjValid=0 -> Hit=1, HitIdx=5, HitMask=0x0220.
REQ-038 Player (0,0,16,16), slot 0 = (16,0,8,8) edge-touching -> Hit=0, HitIdx=0.
REQ-039 Start pulsed again at cycles 5 and 18 of a scan -> both ignored; single Done; Start at cycle 19 accepted.
REQ-040 Reset asserted at cycle 8 of scan -> Busy=0 next sample, no Done, prior Hit/HitIdx cleared to 0.
REQ-041 Run 36 and 37 back-to-back -> outputs hold first result until second Done, then update.
